// File: rtl/instruction_sequencer.sv
// Instruction source for cpu: a host loads a program over valid/ready, then the
// words are issued one per clock in program order, honouring stall and HALT.
module instruction_sequencer #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                         clock_in,
  input  logic                         reset_n_in,
  input  logic                         load_valid_in,
  input  logic [INSTR_WIDTH-1:0]       load_data_in,
  output logic                         load_ready_out,
  input  logic                         start_in,
  input  logic                         clear_in,
  input  logic                         stall_in,
  output logic [INSTR_WIDTH-1:0]       current_instruction,
  output logic                         instruction_valid_out,
  output logic [$clog2(DEPTH)-1:0]     pc_out,
  output logic [$clog2(DEPTH):0]       program_length_out,
  output logic                         busy_out,
  output logic                         done_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_nxt;
  logic [AW:0]            count, count_nxt;
  logic [AW-1:0]          pc, pc_nxt;
  logic [INSTR_WIDTH-1:0] instr, instr_nxt;
  logic                   valid, valid_nxt;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] rd_word;
  logic                   load_fire;
  logic                   halt;
  logic                   last;

  assign load_ready_out        = (state == IDLE) && (count < (AW+1)'(DEPTH));
  assign load_fire             = load_valid_in && load_ready_out && !clear_in;
  assign rd_word               = mem[pc];
  assign halt                  = (rd_word[INSTR_WIDTH-1:INSTR_WIDTH-8] == 8'hFF);
  assign last                  = ({1'b0, pc} == (count - 1'b1));
  assign current_instruction   = instr;
  assign instruction_valid_out = valid;
  assign pc_out                = pc;
  assign program_length_out    = count;
  assign busy_out              = (state == RUN);
  assign done_out              = (state == DONE);

  // Program storage is deliberately not reset.
  always_ff @(posedge clock_in) begin
    if (load_fire) mem[count[AW-1:0]] <= load_data_in;
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state <= IDLE;
      count <= '0;
      pc    <= '0;
      instr <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
      valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pc_nxt    = pc;
    instr_nxt = instr;
    valid_nxt = valid;
    if (clear_in) begin
      state_nxt = IDLE;
      count_nxt = '0;
      pc_nxt    = '0;
      instr_nxt = '0;
      valid_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_fire) count_nxt = count + 1'b1;
          if (start_in && (count != '0)) begin
            state_nxt = RUN;
            pc_nxt    = '0;
          end
        end
        RUN: begin
          if (!stall_in) begin
            // HALT only moves to DONE; the previous word is cleared on the DONE edge.
            if (halt) begin
              state_nxt = DONE;
            end else begin
              instr_nxt = rd_word;
              valid_nxt = 1'b1;
              // pc parks on the last index instead of wrapping past it.
              if (last) state_nxt = DONE;
              else      pc_nxt    = pc + 1'b1;
            end
          end
        end
        DONE: begin
          instr_nxt = '0;
          valid_nxt = 1'b0;
          if (start_in) begin
            state_nxt = RUN;
            pc_nxt    = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed self-checking bench for instruction_sequencer: load, run, full memory,
// HALT, stall, clear, re-run and asynchronous reset.
module tb_instruction_sequencer;

  logic        clock_in;
  logic        reset_n_in;
  logic        load_valid_in;
  logic [31:0] load_data_in;
  logic        load_ready_out;
  logic        start_in;
  logic        clear_in;
  logic        stall_in;
  logic [31:0] current_instruction;
  logic        instruction_valid_out;
  logic [5:0]  pc_out;
  logic [6:0]  program_length_out;
  logic        busy_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;

  instruction_sequencer #(.DEPTH(64), .INSTR_WIDTH(32)) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .load_valid_in(load_valid_in), .load_data_in(load_data_in), .load_ready_out(load_ready_out),
    .start_in(start_in), .clear_in(clear_in), .stall_in(stall_in),
    .current_instruction(current_instruction), .instruction_valid_out(instruction_valid_out),
    .pc_out(pc_out), .program_length_out(program_length_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic do_clear();
    clear_in = 1'b1; step(); clear_in = 1'b0;
  endtask

  task automatic load_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      load_valid_in = 1'b1; load_data_in = base + 32'(i); step();
    end
    load_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_in = 1'b0; load_valid_in = 1'b0; load_data_in = '0;
    start_in = 1'b0; clear_in = 1'b0; stall_in = 1'b0;
    #12;
    checks++; if (current_instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", current_instruction); end
    checks++; if (instruction_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instruction_valid_out); end
    checks++; if (pc_out !== 6'd0 || program_length_out !== 7'd0) begin errors++; $display("FAIL reset_pc_len got %0d/%0d want 0/0", pc_out, program_length_out); end
    checks++; if (load_ready_out !== 1'b1 || busy_out !== 1'b0 || done_out !== 1'b0) begin errors++; $display("FAIL reset_flags got rdy%b busy%b done%b want 1 0 0", load_ready_out, busy_out, done_out); end
    #1 reset_n_in = 1'b1;
    step();
  endtask

  task automatic test_basic_run();
    load_words(32'h0100_0001, 4);
    checks++; if (program_length_out !== 7'd4) begin errors++; $display("FAIL basic_len got %0d want 4", program_length_out); end
    start_in = 1'b1; step(); start_in = 1'b0;
    checks++; if (busy_out !== 1'b1 || instruction_valid_out !== 1'b0) begin errors++; $display("FAIL basic_start got busy%b valid%b want 1 0", busy_out, instruction_valid_out); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (current_instruction !== 32'h0100_0001 + 32'(i) || instruction_valid_out !== 1'b1) begin errors++; $display("FAIL basic_word%0d got %h v%b want %h v1", i, current_instruction, instruction_valid_out, 32'h0100_0001 + 32'(i)); end
      checks++; if (done_out !== (i == 3)) begin errors++; $display("FAIL basic_done%0d got %b want %b", i, done_out, (i == 3)); end
    end
    step();
    checks++; if (current_instruction !== 32'h0 || instruction_valid_out !== 1'b0 || done_out !== 1'b1) begin errors++; $display("FAIL basic_after got %h v%b d%b want 0 v0 d1", current_instruction, instruction_valid_out, done_out); end
    checks++; if (load_ready_out !== 1'b0) begin errors++; $display("FAIL basic_done_noload got %b want 0", load_ready_out); end
  endtask

  task automatic test_full_memory();
    do_clear();
    for (int i = 0; i < 64; i++) begin
      load_valid_in = 1'b1; load_data_in = 32'h0200_0000 + 32'(i);
      checks++; if (load_ready_out !== 1'b1) begin errors++; $display("FAIL full_ready%0d got %b want 1", i, load_ready_out); end
      step();
    end
    load_data_in = 32'h0200_0040;
    checks++; if (load_ready_out !== 1'b0) begin errors++; $display("FAIL full_notready got %b want 0", load_ready_out); end
    step(); step();
    checks++; if (program_length_out !== 7'd64) begin errors++; $display("FAIL full_len got %0d want 64", program_length_out); end
    load_valid_in = 1'b0;
    start_in = 1'b1; step(); start_in = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      checks++; if (current_instruction !== 32'h0200_0000 + 32'(i) || instruction_valid_out !== 1'b1) begin errors++; $display("FAIL full_word%0d got %h want %h", i, current_instruction, 32'h0200_0000 + 32'(i)); end
      checks++; if (pc_out !== 6'((i == 63) ? 63 : i + 1)) begin errors++; $display("FAIL full_pc%0d got %0d want %0d", i, pc_out, (i == 63) ? 63 : i + 1); end
    end
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL full_done got %b want 1", done_out); end
  endtask

  task automatic test_halt();
    do_clear();
    load_valid_in = 1'b1;
    load_data_in = 32'h0A00_0001; step();
    load_data_in = 32'h0B00_0002; step();
    load_data_in = 32'hFF00_0000; step();
    load_data_in = 32'h0C00_0003; step();
    load_valid_in = 1'b0;
    start_in = 1'b1; step(); start_in = 1'b0;
    step();
    checks++; if (current_instruction !== 32'h0A00_0001 || instruction_valid_out !== 1'b1) begin errors++; $display("FAIL halt_A got %h want 0a000001", current_instruction); end
    step();
    checks++; if (current_instruction !== 32'h0B00_0002 || done_out !== 1'b0) begin errors++; $display("FAIL halt_B got %h d%b want 0b000002 d0", current_instruction, done_out); end
    step();
    checks++; if (done_out !== 1'b1 || current_instruction !== 32'h0B00_0002) begin errors++; $display("FAIL halt_edge got d%b %h want d1 0b000002", done_out, current_instruction); end
    step();
    checks++; if (current_instruction !== 32'h0 || instruction_valid_out !== 1'b0) begin errors++; $display("FAIL halt_after got %h v%b want 0 v0", current_instruction, instruction_valid_out); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (current_instruction === 32'h0C00_0003 || done_out !== 1'b1) begin errors++; $display("FAIL halt_noC got %h d%b want not 0c000003 d1", current_instruction, done_out); end
    end
  endtask

  task automatic test_stall();
    int vcount = 0;
    do_clear();
    load_words(32'h0300_0000, 3);
    start_in = 1'b1; step(); start_in = 1'b0;
    step(); vcount += int'(instruction_valid_out);
    checks++; if (current_instruction !== 32'h0300_0000) begin errors++; $display("FAIL stall_w0 got %h want 03000000", current_instruction); end
    step(); vcount += int'(instruction_valid_out);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); vcount += int'(instruction_valid_out);
      checks++; if (current_instruction !== 32'h0300_0001 || pc_out !== 6'd2 || instruction_valid_out !== 1'b1) begin errors++; $display("FAIL stall_hold%0d got %h pc%0d want 03000001 pc2", i, current_instruction, pc_out); end
    end
    stall_in = 1'b0;
    step(); vcount += int'(instruction_valid_out);
    checks++; if (current_instruction !== 32'h0300_0002 || done_out !== 1'b1) begin errors++; $display("FAIL stall_w2 got %h d%b want 03000002 d1", current_instruction, done_out); end
    step(); vcount += int'(instruction_valid_out);
    checks++; if (vcount != 5) begin errors++; $display("FAIL stall_valid_cycles got %0d want 5", vcount); end
  endtask

  task automatic test_clear();
    do_clear();
    load_words(32'h0400_0000, 3);
    start_in = 1'b1; step(); start_in = 1'b0;
    step();
    clear_in = 1'b1; stall_in = 1'b1; step(); clear_in = 1'b0; stall_in = 1'b0;
    checks++; if (busy_out !== 1'b0 || done_out !== 1'b0 || current_instruction !== 32'h0 || instruction_valid_out !== 1'b0) begin errors++; $display("FAIL clear_state got b%b d%b %h v%b want 0 0 0 0", busy_out, done_out, current_instruction, instruction_valid_out); end
    checks++; if (program_length_out !== 7'd0 || load_ready_out !== 1'b1 || pc_out !== 6'd0) begin errors++; $display("FAIL clear_regs got len%0d rdy%b pc%0d want 0 1 0", program_length_out, load_ready_out, pc_out); end
    start_in = 1'b1; step(); start_in = 1'b0;
    checks++; if (busy_out !== 1'b0 || instruction_valid_out !== 1'b0) begin errors++; $display("FAIL clear_empty_start got b%b v%b want 0 0", busy_out, instruction_valid_out); end
  endtask

  task automatic test_rerun_and_reset();
    do_clear();
    load_words(32'h0500_00AA, 2);
    for (int r = 0; r < 2; r++) begin
      start_in = 1'b1; step(); start_in = 1'b0;
      step();
      checks++; if (current_instruction !== 32'h0500_00AA) begin errors++; $display("FAIL rerun%0d_w0 got %h want 050000aa", r, current_instruction); end
      step();
      checks++; if (current_instruction !== 32'h0500_00AB || done_out !== 1'b1) begin errors++; $display("FAIL rerun%0d_w1 got %h d%b want 050000ab d1", r, current_instruction, done_out); end
      step();
    end
    start_in = 1'b1; step(); start_in = 1'b0;
    step();
    #2 reset_n_in = 1'b0;
    #1;
    checks++; if (current_instruction !== 32'h0 || instruction_valid_out !== 1'b0 || busy_out !== 1'b0) begin errors++; $display("FAIL async_reset got %h v%b b%b want 0 0 0", current_instruction, instruction_valid_out, busy_out); end
    checks++; if (program_length_out !== 7'd0 || pc_out !== 6'd0 || load_ready_out !== 1'b1) begin errors++; $display("FAIL async_reset_regs got len%0d pc%0d rdy%b want 0 0 1", program_length_out, pc_out, load_ready_out); end
    #1 reset_n_in = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_full_memory();
    test_halt();
    test_stall();
    test_clear();
    test_rerun_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Hardware instruction source for `cpu`: it drives `cpu.current_instruction` and replaces the simulation-only stimulus path. A host writes up to DEPTH 32-bit instruction words over a valid/ready load port. On `start_in`, the block issues them to the CPU one per clock in program order, honouring a stall input and a HALT opcode. It then parks in DONE, and the program can be re-run or cleared.

## Interface
- DEPTH, 64, instruction memory depth in words; power of two, ≥2.
- INSTR_WIDTH, 32, instruction word width.
- clock_in  input  1  system clock; all state updates on rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- load_valid_in  input  1  host presents an instruction word.
- load_data_in  input  INSTR_WIDTH  instruction word to append.
- load_ready_out  output  1  combinational: state==IDLE && count<DEPTH.
- start_in  input  1  begin issuing from address 0.
- clear_in  input  1  synchronous abort/clear; highest priority.
- stall_in  input  1  CPU not accepting; hold current output and pc.
- current_instruction  output  INSTR_WIDTH  registered instruction to cpu; 0 (NOP) when not valid.
- instruction_valid_out  output  1  registered; current_instruction is a live issued word.
- pc_out  output  log2(DEPTH)  registered address of next word to issue.
- program_length_out  output  log2(DEPTH)+1  registered count of loaded words.
- busy_out  output  1  state==RUN.
- done_out  output  1  state==DONE.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, count=0, pc=0, current_instruction=0, instruction_valid_out=0. load_ready_out reads 1 after reset.
- Memory contents are not reset. Contents are undefined until loaded.
- IDLE:
  - A load beat is accepted when load_valid_in && load_ready_out. The edge writes mem[count]<=load_data_in and sets count<=count+1.
  - If count==DEPTH, load_ready_out=0 and the beat is not accepted; the host holds it.
  - If start_in=1 and pre-edge count>0: state<=RUN, pc<=0.
  - If start_in=1 and count==0: ignored.
  - A simultaneous accepted load beat is still written and is part of the run.
- RUN, each edge with stall_in=0:
  - If mem[pc][31:24]==8'hFF (HALT): state<=DONE. The HALT word is not issued.
  - Otherwise: current_instruction<=mem[pc], instruction_valid_out<=1, pc<=pc+1.
  - If pc==count-1: state<=DONE.
- RUN with stall_in=1: current_instruction, instruction_valid_out and pc hold.
- DONE:
  - First edge sets current_instruction<=0 and instruction_valid_out<=0.
  - start_in re-enters RUN with pc<=0, same program.
  - Loads are refused.
- clear_in=1 in any state:
  - state<=IDLE, count<=0, pc<=0.
  - current_instruction<=0, instruction_valid_out<=0.
  - Overrides start, load and stall on the same edge.
- Asserting reset_n_in low mid-RUN immediately forces all registered outputs to reset values.
- pc never wraps: the maximum issued index is count-1 ≤ DEPTH-1.

## Timing
- Start sampled at edge E0 → word i appears on current_instruction after edge E0+1+i, absent stalls.
- instruction_valid_out is high for exactly N consecutive cycles for an N-word program without HALT or stall.
- done_out rises on the edge that issues the last word. Valid drops one edge later.
- Each stall cycle delays all later words by exactly one cycle. Stall has no effect in IDLE and DONE.
- Load throughput: one word per cycle while ready.
- done_out and busy_out decode the state register; no added latency.

## Test plan
- Reset, then load 4 words 0x01000001..0x01000004 back-to-back, then pulse start → program_length_out=4; words appear on 4 consecutive cycles starting 2 edges after start; done_out=1 with the 4th word; valid=0 and output=0 next cycle.
- Load 64 words, then hold load_valid_in with a 65th word → load_ready_out=0 after the 64th acceptance; count stays 64; run issues all 64 words with pc_out reaching 63 and no wrap.
- Program [A, B, 0xFF000000, C], start → only A and B are issued; done_out asserts on the edge that would have issued HALT; C is never driven.
- 3-word program with stall_in high for 2 cycles while word 1 is on the output → word 1 is held for 3 cycles total; word 2 follows; total valid cycles = 5.
- clear_in during RUN after word 0 → next edge: IDLE, output 0, valid 0, program_length_out=0, load_ready_out=1. Start with count 0 is ignored.
- Start in DONE re-runs the identical sequence. Asserting reset_n_in low mid-run zeroes outputs immediately without waiting for a clock edge.
